// File: rtl/param_delay_line_pkg.sv
// Shared definitions for the parametrised delay line: default sizes and the
// ceiling-log2 helper used to size the tap select and occupancy ports.
package param_delay_line_pkg;

  localparam int DLY_WIDTH_DEF = 8;
  localparam int DLY_DEPTH_DEF = 4;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/param_delay_line_stage.sv
// One delay-line stage: WIDTH data bits plus a valid flag held in a single
// WIDTH+1-bit register. Asynchronous reset, synchronous clear, clock enable.
// This is the successor of the plain single-bit D flip-flop.
module dly_stage
  import param_delay_line_pkg::*;
#(
  parameter int               WIDTH   = DLY_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  // Valid flag in the MSB, data below it.
  logic [WIDTH:0] stage_q;

  // Stage register: rst and sclr load RST_VAL with the flag cleared; en loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {1'b0, RST_VAL};
    end else if (sclr) begin
      stage_q <= {1'b0, RST_VAL};
    end else if (en) begin
      stage_q <= {d_valid, d_data};
    end
  end

  assign q_data  = stage_q[WIDTH-1:0];
  assign q_valid = stage_q[WIDTH];

endmodule

// File: rtl/param_delay_line.sv
// Enable-gated WIDTH x DEPTH register pipeline with per-stage valid flags,
// a combinational tap on any stage and a registered occupancy counter.
// Latency is DEPTH enabled edges; dout comes straight from the last stage.
module param_delay_line
  import param_delay_line_pkg::*;
#(
  parameter int               WIDTH   = DLY_WIDTH_DEF,
  parameter int               DEPTH   = DLY_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               TAP_W   = (DEPTH > 1) ? clog2(DEPTH) : 1,
  parameter int               OCC_W   = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [TAP_W-1:0] tap_sel,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] stg_vld;
  logic [OCC_W-1:0] occ_q;

  // Stage 0 takes din; every later stage takes the previous stage's output.
  // Data shifts regardless of its flag; only the flags mark meaningful samples.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      dly_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sclr    (sclr),
        .d_data  (din),
        .d_valid (din_valid),
        .q_data  (stg_data[i]),
        .q_valid (stg_vld[i])
      );
    end else begin : g_next
      dly_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sclr    (sclr),
        .d_data  (stg_data[i-1]),
        .d_valid (stg_vld[i-1]),
        .q_data  (stg_data[i]),
        .q_valid (stg_vld[i])
      );
    end
  end

  assign dout       = stg_data[DEPTH-1];
  assign dout_valid = stg_vld[DEPTH-1];

  // Tap mux over the registered stages; an index past the last stage reads as empty.
  always_comb begin
    tap_data  = RST_VAL;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_data  = stg_data[i];
        tap_valid = stg_vld[i];
      end
    end
  end

  // Occupancy tracks entries minus exits on enabled edges instead of a popcount,
  // keeping it a short registered adder independent of DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (sclr) begin
      occ_q <= '0;
    end else if (en) begin
      occ_q <= occ_q + OCC_W'(din_valid) - OCC_W'(stg_vld[DEPTH-1]);
    end
  end

  assign occupancy = occ_q;

endmodule
